// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - forwarding-select encodings driven on o_fwd_a / o_fwd_b
//   - stage_rec_t, the shadow record kept for the EX, MEM and WB stages
// Register indices inside a record are REC_ADDR_W bits wide. The top level
// zero-extends its REG_ADDR_W indices into them, so REG_ADDR_W must not
// exceed REC_ADDR_W. Zero-extension keeps every equality compare exact.
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM ALU result
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB write data

    localparam int REC_ADDR_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [REC_ADDR_W-1:0] rd;
        logic [REC_ADDR_W-1:0] rs1;
        logic [REC_ADDR_W-1:0] rs2;
        logic                  uses_rs1;
        logic                  uses_rs2;
        logic                  reg_write;
        logic                  mem_read;
    } stage_rec_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational comparator between one source register and one stage record.
// A source matches only when it is actually read, is not x0, and equals the
// destination of a valid record that writes the register file.
// Ports:
//   rs    in  REC_ADDR_W  source register index (zero-extended)
//   uses  in  1           source is read (caller may fold a valid in here)
//   rec   in  stage_rec_t record being compared against
//   match out 1           RAW dependency on rec
// -----------------------------------------------------------------------------
module hazard_match
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REC_ADDR_W-1:0] rs,
    input  logic                  uses,
    input  stage_rec_t            rec,
    output logic                  match
);

    assign match = uses && (rs != '0) && rec.valid && rec.reg_write
                   && (rec.rd == rs);

    // Source-side fields of the record are irrelevant to this comparison.
    logic unused_rec_fields;
    assign unused_rec_fields = ^{rec.rs1, rec.rs2, rec.uses_rs1,
                                 rec.uses_rs2, rec.mem_read};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard unit for a 5-stage in-order pipeline. Tracks shadow records of the
// instructions in EX, MEM and WB and, from the instruction in ID, produces
// stall / bubble, flush, forwarding and ID-bypass controls plus two
// saturating performance counters.
// Parameters:
//   REG_ADDR_W    register index width (<= REC_ADDR_W)
//   CNT_W         performance counter width
//   BRANCH_STAGE  1 = branches resolve in EX, 2 = in MEM
//   FWD_EN        1 = forwarding, stall only on load-use; 0 = stall on any RAW
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_id_valid                      ID holds a real instruction
//   i_id_rs1/rs2, i_id_uses_rs1/rs2 ID sources and their use flags
//   i_id_rd, i_id_reg_write         ID destination and its write enable
//   i_id_mem_read                   ID instruction is a load
//   i_branch_taken                  branch resolved taken this cycle
//   i_cnt_clear                     zero both counters
//   o_pc_stall, o_if_id_stall       hold PC / IF-ID register
//   o_id_ex_bubble                  insert NOP into ID/EX
//   o_if_id_flush, o_id_ex_flush,
//   o_ex_mem_flush                  invalidate that pipeline register
//   o_fwd_a, o_fwd_b                EX operand selects (FWD_* encodings)
//   o_id_bypass_a, o_id_bypass_b    ID read takes MEM/WB write data
//   o_stall_cnt, o_flush_cnt        stall cycles / flush events
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 32,
    parameter int BRANCH_STAGE = 2,
    parameter int FWD_EN       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
    input  logic                  i_branch_taken,
    input  logic                  i_cnt_clear,
    output logic                  o_pc_stall,
    output logic                  o_if_id_stall,
    output logic                  o_id_ex_bubble,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_flush,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic                  o_id_bypass_a,
    output logic                  o_id_bypass_b,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_rec_t ex_q, mem_q, wb_q;
    stage_rec_t id_rec;
    stage_rec_t recs [3];          // 0 = EX, 1 = MEM, 2 = WB

    logic [2:0] id_m1, id_m2;      // ID source vs EX/MEM/WB
    logic [1:0] ex_m1, ex_m2;      // EX source vs MEM/WB
    logic       raw, stall, flush;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_comb begin
        id_rec           = '0;
        id_rec.valid     = i_id_valid;
        id_rec.rd        = REC_ADDR_W'(i_id_rd);
        id_rec.rs1       = REC_ADDR_W'(i_id_rs1);
        id_rec.rs2       = REC_ADDR_W'(i_id_rs2);
        id_rec.uses_rs1  = i_id_uses_rs1;
        id_rec.uses_rs2  = i_id_uses_rs2;
        id_rec.reg_write = i_id_reg_write;
        id_rec.mem_read  = i_id_mem_read;
    end

    assign recs[0] = ex_q;
    assign recs[1] = mem_q;
    assign recs[2] = wb_q;

    // ID sources only count when ID holds a real instruction, so an idle
    // ID stage can never stall or request a bypass.
    for (genvar s = 0; s < 3; s++) begin : g_id_match
        hazard_match u_rs1 (
            .rs    (id_rec.rs1),
            .uses  (i_id_valid && i_id_uses_rs1),
            .rec   (recs[s]),
            .match (id_m1[s])
        );
        hazard_match u_rs2 (
            .rs    (id_rec.rs2),
            .uses  (i_id_valid && i_id_uses_rs2),
            .rec   (recs[s]),
            .match (id_m2[s])
        );
    end

    // EX sources are compared against the two older records only; a bubble
    // in EX never selects a forwarding path.
    for (genvar s = 0; s < 2; s++) begin : g_ex_match
        hazard_match u_rs1 (
            .rs    (ex_q.rs1),
            .uses  (ex_q.valid && ex_q.uses_rs1),
            .rec   (recs[s+1]),
            .match (ex_m1[s])
        );
        hazard_match u_rs2 (
            .rs    (ex_q.rs2),
            .uses  (ex_q.valid && ex_q.uses_rs2),
            .rec   (recs[s+1]),
            .match (ex_m2[s])
        );
    end

    always_comb begin
        raw     = 1'b0;
        o_fwd_a = FWD_REG;
        o_fwd_b = FWD_REG;
        o_id_bypass_a = 1'b0;
        o_id_bypass_b = 1'b0;
        if (FWD_EN != 0) begin
            // Only a load in EX cannot be forwarded in time.
            raw = (id_m1[0] || id_m2[0]) && ex_q.mem_read;
            // MEM is the younger producer, so it has priority over WB.
            if (ex_m1[0])      o_fwd_a = FWD_MEM;
            else if (ex_m1[1]) o_fwd_a = FWD_WB;
            if (ex_m2[0])      o_fwd_b = FWD_MEM;
            else if (ex_m2[1]) o_fwd_b = FWD_WB;
            o_id_bypass_a = id_m1[2];
            o_id_bypass_b = id_m2[2];
        end else begin
            raw = (|id_m1) || (|id_m2);
        end
    end

    // A taken branch discards the stalled instruction anyway, so flush wins.
    assign flush = i_branch_taken;
    assign stall = raw && !flush;

    assign o_pc_stall     = stall;
    assign o_if_id_stall  = stall;
    assign o_id_ex_bubble = stall;
    assign o_if_id_flush  = flush;
    assign o_id_ex_flush  = flush;
    assign o_ex_mem_flush = flush && (BRANCH_STAGE == 2);

    // Records younger than the branch are dropped: ID always, and the EX
    // instruction as well when the branch sits in MEM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (flush && (BRANCH_STAGE == 2)) mem_q.valid <= 1'b0;
            ex_q  <= id_rec;
            if (!i_id_valid || stall || flush) ex_q.valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_cnt_clear) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != CNT_MAX))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != CNT_MAX))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Two controller instances share clock and reset:
//   instance 0: FWD_EN=1, BRANCH_STAGE=2, CNT_W=32
//   instance 1: FWD_EN=0, BRANCH_STAGE=1, CNT_W=4
// A pipeline-level model (which instruction sits how far downstream, who is
// the nearest producer of a register) predicts every output each cycle.
// Directed sequences also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- per-instance stimulus and observation ----------------
    logic       id_valid [2];
    logic [4:0] id_rs1 [2], id_rs2 [2], id_rd [2];
    logic       id_u1 [2], id_u2 [2], id_wr [2], id_ld [2];
    logic       br [2], clr [2];

    logic       pc_stall [2], if_id_stall [2], bubble [2];
    logic       f_ifid [2], f_idex [2], f_exmem [2];
    logic [1:0] fwd_a [2], fwd_b [2];
    logic       byp_a [2], byp_b [2];
    logic [31:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32), .BRANCH_STAGE(2), .FWD_EN(1)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid[0]),
        .i_id_rs1(id_rs1[0]), .i_id_rs2(id_rs2[0]),
        .i_id_uses_rs1(id_u1[0]), .i_id_uses_rs2(id_u2[0]),
        .i_id_rd(id_rd[0]), .i_id_reg_write(id_wr[0]), .i_id_mem_read(id_ld[0]),
        .i_branch_taken(br[0]), .i_cnt_clear(clr[0]),
        .o_pc_stall(pc_stall[0]), .o_if_id_stall(if_id_stall[0]), .o_id_ex_bubble(bubble[0]),
        .o_if_id_flush(f_ifid[0]), .o_id_ex_flush(f_idex[0]), .o_ex_mem_flush(f_exmem[0]),
        .o_fwd_a(fwd_a[0]), .o_fwd_b(fwd_b[0]),
        .o_id_bypass_a(byp_a[0]), .o_id_bypass_b(byp_b[0]),
        .o_stall_cnt(sc0), .o_flush_cnt(fc0)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4), .BRANCH_STAGE(1), .FWD_EN(0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid[1]),
        .i_id_rs1(id_rs1[1]), .i_id_rs2(id_rs2[1]),
        .i_id_uses_rs1(id_u1[1]), .i_id_uses_rs2(id_u2[1]),
        .i_id_rd(id_rd[1]), .i_id_reg_write(id_wr[1]), .i_id_mem_read(id_ld[1]),
        .i_branch_taken(br[1]), .i_cnt_clear(clr[1]),
        .o_pc_stall(pc_stall[1]), .o_if_id_stall(if_id_stall[1]), .o_id_ex_bubble(bubble[1]),
        .o_if_id_flush(f_ifid[1]), .o_id_ex_flush(f_idex[1]), .o_ex_mem_flush(f_exmem[1]),
        .o_fwd_a(fwd_a[1]), .o_fwd_b(fwd_b[1]),
        .o_id_bypass_a(byp_a[1]), .o_id_bypass_b(byp_b[1]),
        .o_stall_cnt(sc1), .o_flush_cnt(fc1)
    );

    function automatic int fwd_en_of(int k);   return (k == 0) ? 1 : 0;  endfunction
    function automatic int br_stage_of(int k); return (k == 0) ? 2 : 1;  endfunction
    function automatic int cnt_w_of(int k);    return (k == 0) ? 32 : 4; endfunction

    function automatic logic [31:0] act_sc(int k);
        return (k == 0) ? sc0 : {28'd0, sc1};
    endfunction
    function automatic logic [31:0] act_fc(int k);
        return (k == 0) ? fc0 : {28'd0, fc1};
    endfunction

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instance keeps the instructions downstream of ID, ordered by
    // distance: index 0 is one stage ahead of ID (EX), 2 is three (WB).
    typedef struct {
        bit v;
        int rd, rs1, rs2;
        bit u1, u2, wr, ld;
    } ins_t;

    ins_t   pipe [2][3];
    longint m_sc [2];
    longint m_fc [2];

    function automatic bit produces(ins_t p, int r, bit used);
        return used && (r != 0) && p.v && p.wr && (p.rd == r);
    endfunction

    task automatic model_step(input int k);
        ins_t   id, e, empty;
        bit     stall, flush, dep_ex, dep_any, bp_a, bp_b;
        int     fa, fb;
        longint cmax;
        empty = '{default: 0};
        id = '{v: id_valid[k], rd: int'(id_rd[k]), rs1: int'(id_rs1[k]), rs2: int'(id_rs2[k]),
               u1: id_u1[k], u2: id_u2[k], wr: id_wr[k], ld: id_ld[k]};
        dep_ex  = id.v && (produces(pipe[k][0], id.rs1, id.u1) || produces(pipe[k][0], id.rs2, id.u2));
        dep_any = 1'b0;
        for (int d = 0; d < 3; d++)
            if (id.v && (produces(pipe[k][d], id.rs1, id.u1) || produces(pipe[k][d], id.rs2, id.u2)))
                dep_any = 1'b1;
        flush = br[k];
        if (fwd_en_of(k) != 0) stall = dep_ex && pipe[k][0].ld && !flush;
        else                   stall = dep_any && !flush;

        // EX operand comes from its nearest older producer: one stage ahead
        // is the ALU result (2'b10), two ahead is the write data (2'b01).
        e = pipe[k][0];
        fa = 0; fb = 0;
        if ((fwd_en_of(k) != 0) && e.v) begin
            for (int d = 1; d <= 2; d++) begin
                if (fa == 0 && produces(pipe[k][d], e.rs1, e.u1)) fa = (d == 1) ? 2 : 1;
                if (fb == 0 && produces(pipe[k][d], e.rs2, e.u2)) fb = (d == 1) ? 2 : 1;
            end
        end
        bp_a = (fwd_en_of(k) != 0) && id.v && produces(pipe[k][2], id.rs1, id.u1);
        bp_b = (fwd_en_of(k) != 0) && id.v && produces(pipe[k][2], id.rs2, id.u2);

        cmp(k, "pc_stall",     32'(pc_stall[k]),    32'(stall));
        cmp(k, "if_id_stall",  32'(if_id_stall[k]), 32'(stall));
        cmp(k, "id_ex_bubble", 32'(bubble[k]),      32'(stall));
        cmp(k, "if_id_flush",  32'(f_ifid[k]),      32'(flush));
        cmp(k, "id_ex_flush",  32'(f_idex[k]),      32'(flush));
        cmp(k, "ex_mem_flush", 32'(f_exmem[k]),     32'(flush && br_stage_of(k) == 2));
        cmp(k, "fwd_a",        32'(fwd_a[k]),       32'(fa));
        cmp(k, "fwd_b",        32'(fwd_b[k]),       32'(fb));
        cmp(k, "bypass_a",     32'(byp_a[k]),       32'(bp_a));
        cmp(k, "bypass_b",     32'(byp_b[k]),       32'(bp_b));
        cmp(k, "stall_cnt",    act_sc(k),           32'(m_sc[k]));
        cmp(k, "flush_cnt",    act_fc(k),           32'(m_fc[k]));

        // advance to the state after the coming rising edge
        cmax = (longint'(1) << cnt_w_of(k)) - 1;
        if (rst) begin
            for (int d = 0; d < 3; d++) pipe[k][d] = empty;
            m_sc[k] = 0;
            m_fc[k] = 0;
        end else begin
            pipe[k][2] = pipe[k][1];
            pipe[k][1] = pipe[k][0];
            if (flush && br_stage_of(k) == 2) pipe[k][1].v = 1'b0;
            pipe[k][0] = id;
            if (stall || flush) pipe[k][0].v = 1'b0;
            if (clr[k]) begin
                m_sc[k] = 0;
                m_fc[k] = 0;
            end else begin
                if (stall && m_sc[k] < cmax) m_sc[k]++;
                if (flush && m_fc[k] < cmax) m_fc[k]++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 3; d++) pipe[k][d] = '{default: 0};
            m_sc[k] = 0;
            m_fc[k] = 0;
        end
    end

    // compare process: every falling edge, both instances
    always @(negedge clk) begin
        if (chk_en) begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int k, input bit v, input int rd, input int rs1, input int rs2,
                         input bit u1, input bit u2, input bit wr, input bit ld,
                         input bit b, input bit c);
        @(posedge clk);
        #1;
        id_valid[k] = v;
        id_rd[k]    = 5'(rd);
        id_rs1[k]   = 5'(rs1);
        id_rs2[k]   = 5'(rs2);
        id_u1[k]    = u1;
        id_u2[k]    = u2;
        id_wr[k]    = wr;
        id_ld[k]    = ld;
        br[k]       = b;
        clr[k]      = c;
    endtask

    // ALU op (reads rs1, rs2) or load (reads rs1 only); both write rd.
    task automatic ins(input int k, input int rd, input int rs1, input int rs2,
                       input bit ld, input bit b, input bit c);
        drive(k, 1'b1, rd, rs1, rs2, 1'b1, !ld, 1'b1, ld, b, c);
    endtask

    task automatic nop(input int k, input bit c);
        drive(k, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endtask

    task automatic drain(input int k);
        repeat (3) nop(k, 1'b0);
    endtask

    task automatic lit(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp(k, name, act, exp);
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            id_valid[k] = 0; id_rd[k] = 0; id_rs1[k] = 0; id_rs2[k] = 0;
            id_u1[k] = 0; id_u2[k] = 0; id_wr[k] = 0; id_ld[k] = 0;
            br[k] = 0; clr[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // idle after reset: everything quiet
        @(negedge clk);
        lit(0, "rst_pc_stall", 32'(pc_stall[0]), 0);
        lit(0, "rst_fwd_a", 32'(fwd_a[0]), 0);
        lit(0, "rst_stall_cnt", sc0, 0);
        lit(1, "rst_flush_cnt", act_fc(1), 0);

        // lw x5 ; add x6,x5,x1 : one stall, then WB forwarding
        ins(0, 5, 2, 0, 1, 0, 0);
        ins(0, 6, 5, 1, 0, 0, 0);
        @(negedge clk);
        lit(0, "lu_stall", 32'(pc_stall[0]), 1);
        lit(0, "lu_bubble", 32'(bubble[0]), 1);
        ins(0, 6, 5, 1, 0, 0, 0);
        @(negedge clk);
        lit(0, "lu_release", 32'(pc_stall[0]), 0);
        lit(0, "lu_stall_cnt", sc0, 1);
        nop(0, 0);
        @(negedge clk);
        lit(0, "lu_fwd_a", 32'(fwd_a[0]), 1);
        lit(0, "lu_fwd_b", 32'(fwd_b[0]), 0);
        drain(0);

        // add x5 ; add x6,x5,x5 : no stall, both operands from EX/MEM
        ins(0, 5, 1, 2, 0, 0, 0);
        ins(0, 6, 5, 5, 0, 0, 0);
        @(negedge clk);
        lit(0, "b2b_stall", 32'(pc_stall[0]), 0);
        nop(0, 0);
        @(negedge clk);
        lit(0, "b2b_fwd_a", 32'(fwd_a[0]), 2);
        lit(0, "b2b_fwd_b", 32'(fwd_b[0]), 2);
        drain(0);

        // writer of x0 ; reader of x0 : nothing happens
        ins(0, 0, 1, 2, 0, 0, 0);
        ins(0, 7, 0, 0, 0, 0, 0);
        @(negedge clk);
        lit(0, "x0_stall", 32'(pc_stall[0]), 0);
        lit(0, "x0_bypass", 32'(byp_a[0]), 0);
        nop(0, 0);
        @(negedge clk);
        lit(0, "x0_fwd_a", 32'(fwd_a[0]), 0);
        drain(0);

        // producer three ahead of the reader: ID bypass
        ins(0, 8, 1, 2, 0, 0, 0);
        nop(0, 0);
        nop(0, 0);
        ins(0, 9, 8, 3, 0, 0, 0);
        @(negedge clk);
        lit(0, "byp_a", 32'(byp_a[0]), 1);
        lit(0, "byp_b", 32'(byp_b[0]), 0);
        drain(0);

        // load-use and taken branch together (branch in MEM)
        ins(0, 5, 2, 0, 1, 0, 0);
        ins(0, 6, 5, 1, 0, 1, 0);
        @(negedge clk);
        lit(0, "brlu_if_id_flush", 32'(f_ifid[0]), 1);
        lit(0, "brlu_id_ex_flush", 32'(f_idex[0]), 1);
        lit(0, "brlu_ex_mem_flush", 32'(f_exmem[0]), 1);
        lit(0, "brlu_stall", 32'(pc_stall[0]), 0);
        lit(0, "brlu_if_id_stall", 32'(if_id_stall[0]), 0);
        nop(0, 0);
        @(negedge clk);
        lit(0, "brlu_flush_cnt", fc0, 1);
        lit(0, "brlu_stall_cnt", sc0, 1);
        drain(0);

        // reset asserted in the middle of a load-use stall
        ins(0, 5, 2, 0, 1, 0, 0);
        ins(0, 6, 5, 1, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        lit(0, "rstmid_stall", 32'(pc_stall[0]), 1);
        ins(0, 6, 5, 1, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        lit(0, "rstmid_after", 32'(pc_stall[0]), 0);
        lit(0, "rstmid_stall_cnt", sc0, 0);
        lit(0, "rstmid_flush_cnt", fc0, 0);
        drain(0);

        // no forwarding: dependent right behind producer stalls 3 cycles
        ins(1, 5, 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            ins(1, 6, 5, 1, 0, 0, 0);
            @(negedge clk);
            lit(1, "nf_stall", 32'(pc_stall[1]), 1);
            lit(1, "nf_fwd_a", 32'(fwd_a[1]), 0);
        end
        ins(1, 6, 5, 1, 0, 0, 0);
        @(negedge clk);
        lit(1, "nf_release", 32'(pc_stall[1]), 0);
        nop(1, 0);
        @(negedge clk);
        lit(1, "nf_stall_cnt", act_sc(1), 3);
        drain(1);

        // branch in EX: EX/MEM is left alone
        ins(1, 5, 1, 2, 0, 0, 0);
        ins(1, 6, 5, 1, 0, 1, 0);
        @(negedge clk);
        lit(1, "br1_if_id_flush", 32'(f_ifid[1]), 1);
        lit(1, "br1_ex_mem_flush", 32'(f_exmem[1]), 0);
        lit(1, "br1_stall", 32'(pc_stall[1]), 0);
        nop(1, 0);
        @(negedge clk);
        lit(1, "br1_flush_cnt", act_fc(1), 1);
        lit(1, "br1_stall_cnt", act_sc(1), 3);
        drain(1);

        // 4-bit counter: 20 stall cycles saturate, then clear during a stall
        nop(1, 1);
        for (int p = 0; p < 6; p++) begin
            ins(1, 5, 1, 2, 0, 0, 0);
            repeat (4) ins(1, 6, 5, 1, 0, 0, 0);
        end
        ins(1, 5, 1, 2, 0, 0, 0);
        ins(1, 6, 5, 1, 0, 0, 0);
        ins(1, 6, 5, 1, 0, 0, 0);
        ins(1, 6, 5, 1, 0, 0, 1);
        @(negedge clk);
        lit(1, "sat_stall_cnt", act_sc(1), 15);
        lit(1, "sat_stalling", 32'(pc_stall[1]), 1);
        ins(1, 6, 5, 1, 0, 0, 0);
        @(negedge clk);
        lit(1, "clr_stall_cnt", act_sc(1), 0);
        lit(1, "clr_flush_cnt", act_fc(1), 0);
        drain(1);

        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
